// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the 64-bit ALU: registers decoded operands, then applies
// XZR zeroing, EX/MEM and MEM/WB forwarding and ALUSrc selection in the EX cycle.
module alu_operand_stage #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              IdValid,
  input  logic [REG_AW-1:0] IdRA,
  input  logic [REG_AW-1:0] IdRB,
  input  logic [DATA_W-1:0] IdDataA,
  input  logic [DATA_W-1:0] IdDataB,
  input  logic [DATA_W-1:0] IdImm,
  input  logic              IdALUSrc,
  input  logic [3:0]        IdALUCtrl,
  input  logic [REG_AW-1:0] IdRW,
  input  logic              IdRegWr,
  input  logic              MemRegWr,
  input  logic [REG_AW-1:0] MemRW,
  input  logic [DATA_W-1:0] MemResult,
  input  logic              WbRegWr,
  input  logic [REG_AW-1:0] WbRW,
  input  logic [DATA_W-1:0] WbResult,
  input  logic              Stall,
  input  logic              Flush,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  output logic [3:0]        ALUCtrl,
  output logic              ExValid,
  output logic [REG_AW-1:0] ExRW,
  output logic              ExRegWr,
  output logic              IllegalOp
);

  localparam logic [REG_AW-1:0] XZR = {REG_AW{1'b1}};

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;

  // Operand source resolution, first match wins; a write to XZR never forwards.
  function automatic logic [DATA_W-1:0] fwdOperand(
    input logic [REG_AW-1:0] srcIdx,
    input logic [DATA_W-1:0] regData,
    input logic              memWr,
    input logic [REG_AW-1:0] memIdx,
    input logic [DATA_W-1:0] memData,
    input logic              wbWr,
    input logic [REG_AW-1:0] wbIdx,
    input logic [DATA_W-1:0] wbData
  );
    logic [DATA_W-1:0] res;
    if (srcIdx == XZR)
      res = '0;
    else if (memWr && (memIdx == srcIdx) && (memIdx != XZR))
      res = memData;
    else if (wbWr && (wbIdx == srcIdx) && (wbIdx != XZR))
      res = wbData;
    else
      res = regData;
    return res;
  endfunction

  function automatic logic isLegalOp(input logic [3:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASS: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

  logic              vldP1;
  logic [REG_AW-1:0] rAP1;
  logic [REG_AW-1:0] rBP1;
  logic [DATA_W-1:0] dataAP1;
  logic [DATA_W-1:0] dataBP1;
  logic [DATA_W-1:0] immP1;
  logic              aluSrcP1;
  logic [3:0]        aluCtrlP1;
  logic [REG_AW-1:0] rwP1;
  logic              regWrP1;

  // ---- ID -> EX register boundary ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vldP1     <= 1'b0;
      regWrP1   <= 1'b0;
      rAP1      <= '0;
      rBP1      <= '0;
      dataAP1   <= '0;
      dataBP1   <= '0;
      immP1     <= '0;
      aluSrcP1  <= 1'b0;
      aluCtrlP1 <= '0;
      rwP1      <= '0;
    end else if (Flush) begin
      vldP1   <= 1'b0;
      regWrP1 <= 1'b0;
    end else if (!Stall) begin
      vldP1     <= IdValid;
      regWrP1   <= IdRegWr & IdValid;
      rAP1      <= IdRA;
      rBP1      <= IdRB;
      dataAP1   <= IdDataA;
      dataBP1   <= IdDataB;
      immP1     <= IdImm;
      aluSrcP1  <= IdALUSrc;
      aluCtrlP1 <= IdALUCtrl;
      rwP1      <= IdRW;
    end
  end

  // ---- EX cycle: forwarding and operand select against live Mem/Wb inputs ----
  logic [DATA_W-1:0] fwdA;
  logic [DATA_W-1:0] fwdB;
  logic [DATA_W-1:0] opB;

  always_comb begin
    fwdA = fwdOperand(rAP1, dataAP1, MemRegWr, MemRW, MemResult, WbRegWr, WbRW, WbResult);
    fwdB = fwdOperand(rBP1, dataBP1, MemRegWr, MemRW, MemResult, WbRegWr, WbRW, WbResult);
    opB  = aluSrcP1 ? immP1 : fwdB;
  end

  // A bubble presents AND 0,0 to the ALU.
  assign BusA      = vldP1 ? fwdA      : '0;
  assign BusB      = vldP1 ? opB       : '0;
  assign ALUCtrl   = vldP1 ? aluCtrlP1 : '0;
  assign ExValid   = vldP1;
  assign ExRW      = rwP1;
  assign ExRegWr   = regWrP1;
  assign IllegalOp = vldP1 & ~isLegalOp(aluCtrlP1);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        IdValid;
  logic [4:0]  IdRA, IdRB, IdRW;
  logic [63:0] IdDataA, IdDataB, IdImm;
  logic        IdALUSrc;
  logic [3:0]  IdALUCtrl;
  logic        IdRegWr;
  logic        MemRegWr;
  logic [4:0]  MemRW;
  logic [63:0] MemResult;
  logic        WbRegWr;
  logic [4:0]  WbRW;
  logic [63:0] WbResult;
  logic        Stall, Flush;
  logic [63:0] BusA, BusB;
  logic [3:0]  ALUCtrl;
  logic        ExValid;
  logic [4:0]  ExRW;
  logic        ExRegWr;
  logic        IllegalOp;

  int compared   = 0;
  int mismatched = 0;

  alu_operand_stage #(.DATA_W(64), .REG_AW(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IdValid(IdValid), .IdRA(IdRA), .IdRB(IdRB),
    .IdDataA(IdDataA), .IdDataB(IdDataB), .IdImm(IdImm),
    .IdALUSrc(IdALUSrc), .IdALUCtrl(IdALUCtrl), .IdRW(IdRW), .IdRegWr(IdRegWr),
    .MemRegWr(MemRegWr), .MemRW(MemRW), .MemResult(MemResult),
    .WbRegWr(WbRegWr), .WbRW(WbRW), .WbResult(WbResult),
    .Stall(Stall), .Flush(Flush),
    .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .ExValid(ExValid),
    .ExRW(ExRW), .ExRegWr(ExRegWr), .IllegalOp(IllegalOp)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".BusA"},      BusA,      64'h0);
    checkVal({tag, ".BusB"},      BusB,      64'h0);
    checkVal({tag, ".ALUCtrl"},   ALUCtrl,   64'h0);
    checkVal({tag, ".ExValid"},   ExValid,   64'h0);
    checkVal({tag, ".ExRW"},      ExRW,      64'h0);
    checkVal({tag, ".ExRegWr"},   ExRegWr,   64'h0);
    checkVal({tag, ".IllegalOp"}, IllegalOp, 64'h0);
  endtask

  initial begin
    Reset_n = 1'b0;
    IdValid = 0; IdRA = 0; IdRB = 0; IdRW = 0; IdDataA = 0; IdDataB = 0; IdImm = 0;
    IdALUSrc = 0; IdALUCtrl = 0; IdRegWr = 0;
    MemRegWr = 0; MemRW = 0; MemResult = 0; WbRegWr = 0; WbRW = 0; WbResult = 0;
    Stall = 0; Flush = 0;
    tick(); tick();
    checkAllZero("rst");
    Reset_n = 1'b1;

    // Plain load
    IdValid = 1; IdRA = 1; IdRB = 2; IdDataA = 64'h1234; IdDataB = 64'hABCD0000;
    IdALUCtrl = 2; IdALUSrc = 0; IdRegWr = 1; IdRW = 3;
    tick();
    checkVal("load.BusA",      BusA,      64'h1234);
    checkVal("load.BusB",      BusB,      64'hABCD0000);
    checkVal("load.ALUCtrl",   ALUCtrl,   64'd2);
    checkVal("load.ExValid",   ExValid,   64'd1);
    checkVal("load.ExRW",      ExRW,      64'd3);
    checkVal("load.ExRegWr",   ExRegWr,   64'd1);
    checkVal("load.IllegalOp", IllegalOp, 64'd0);

    // Forwarding priority
    IdRA = 5; IdRB = 5; IdDataA = 64'hAAAA; IdDataB = 64'hBBBB; IdALUCtrl = 1;
    tick();
    MemRegWr = 1; MemRW = 5; MemResult = 64'h11;
    WbRegWr = 1; WbRW = 5; WbResult = 64'h22;
    #1;
    checkVal("fwdMem.BusA", BusA, 64'h11);
    checkVal("fwdMem.BusB", BusB, 64'h11);
    MemRegWr = 0;
    #1;
    checkVal("fwdWb.BusA", BusA, 64'h22);
    checkVal("fwdWb.BusB", BusB, 64'h22);
    WbRegWr = 0;
    #1;
    checkVal("fwdNone.BusA", BusA, 64'hAAAA);
    checkVal("fwdNone.BusB", BusB, 64'hBBBB);

    // XZR zeroing, and writers to X31 never forward
    IdRA = 31; IdDataA = 64'hFFFF; IdRB = 31; IdDataB = 64'hEEEE;
    MemRegWr = 1; MemRW = 31; MemResult = 64'h33;
    WbRegWr = 1; WbRW = 31; WbResult = 64'h44;
    tick();
    checkVal("xzr.BusA", BusA, 64'h0);
    checkVal("xzr.BusB", BusB, 64'h0);
    WbRegWr = 0;

    // Immediate bypasses forwarding
    IdRA = 1; IdDataA = 64'h77; IdRB = 5; IdDataB = 64'h99; IdALUSrc = 1; IdImm = 64'h10;
    MemRW = 5;
    tick();
    checkVal("imm.BusA", BusA, 64'h77);
    checkVal("imm.BusB", BusB, 64'h10);
    IdALUSrc = 0;
    tick();
    checkVal("immOff.BusB", BusB, 64'h33);
    MemRegWr = 0;

    // Stall holds, Flush beats Stall
    IdRA = 2; IdRB = 3; IdDataA = 64'h100; IdDataB = 64'h40; IdALUCtrl = 6;
    IdRegWr = 1; IdRW = 7;
    tick();
    checkVal("sub.ALUCtrl", ALUCtrl, 64'd6);
    Stall = 1;
    IdRA = 9; IdRB = 10; IdDataA = 64'hDEAD; IdDataB = 64'hBEEF; IdALUCtrl = 0; IdRW = 12;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("stall.BusA",    BusA,    64'h100);
      checkVal("stall.BusB",    BusB,    64'h40);
      checkVal("stall.ALUCtrl", ALUCtrl, 64'd6);
      checkVal("stall.ExRW",    ExRW,    64'd7);
    end
    MemRegWr = 1; MemRW = 2; MemResult = 64'h55;
    #1;
    checkVal("stallFwd.BusA", BusA, 64'h55);
    MemRegWr = 0;
    Flush = 1;
    tick();
    checkVal("flush.ExValid",   ExValid,   64'd0);
    checkVal("flush.ExRegWr",   ExRegWr,   64'd0);
    checkVal("flush.BusA",      BusA,      64'h0);
    checkVal("flush.BusB",      BusB,      64'h0);
    checkVal("flush.ALUCtrl",   ALUCtrl,   64'd0);
    checkVal("flush.IllegalOp", IllegalOp, 64'd0);
    Stall = 0; Flush = 0;

    // Illegal opcode flag
    IdValid = 1; IdALUCtrl = 4'h3;
    tick();
    checkVal("ill.IllegalOp", IllegalOp, 64'd1);
    checkVal("ill.ALUCtrl",   ALUCtrl,   64'd3);
    IdALUCtrl = 4'h7;
    tick();
    checkVal("pass.IllegalOp", IllegalOp, 64'd0);
    IdValid = 0; IdALUCtrl = 4'h3;
    tick();
    checkVal("illInv.IllegalOp", IllegalOp, 64'd0);
    checkVal("illInv.ExValid",   ExValid,   64'd0);
    checkVal("illInv.ExRegWr",   ExRegWr,   64'd0);

    // Asynchronous reset mid-cycle
    IdValid = 1; IdALUCtrl = 4'h2; IdRA = 1; IdDataA = 64'h5A; IdRW = 4;
    tick();
    checkVal("pre.ExValid", ExValid, 64'd1);
    #2 Reset_n = 1'b0;
    #1;
    checkAllZero("asyncRst");
    Reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
